// File: rtl/seg_shift_display_driver.sv
// rtl/seg_shift_display_driver.sv - binary to 7-segment frame driver for a 74HC595 display chain
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits, dash hugs the number).
module seg_shift_display_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5,
  parameter int SR_CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_2s_comp,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_sr_data,
  output logic                  o_sr_clk,
  output logic                  o_sr_latch
);

  // Every 3 input bits add less than one decimal digit, so this always holds the full value.
  localparam int BCD_DIGITS = (DATA_WIDTH + 2) / 3;
  localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int BCDW       = 4 * BCD_DIGITS;
  localparam int EXTW       = 4 * EXT_DIGITS;
  localparam int NB         = NUM_DIGITS * 8;
  localparam int CW         = $clog2(DATA_WIDTH + 1);
  localparam int BW         = $clog2(NB + 1);
  localparam int DW         = $clog2(2 * SR_CLK_DIV + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(SR_CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * SR_CLK_DIV - 1);
  localparam logic [7:0]    SEG_DASH = 8'h40;

  typedef enum logic [2:0] {IDLE, CONVERT, ENCODE, SHIFT, LATCH} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mag;
  logic [BCDW-1:0]       r_bcd;
  logic                  r_neg;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DW-1:0]         r_div;
  logic [NB-1:0]         r_frame;
  logic                  r_sr_data;
  logic                  r_sr_clk;
  logic                  r_sr_latch;

  logic [BCDW-1:0]       w_bcd_adj;
  logic [EXTW-1:0]       w_bcd_ext;
  logic [NB-1:0]         w_frame;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'h3F;
      4'd1:    seg_of = 8'h06;
      4'd2:    seg_of = 8'h5B;
      4'd3:    seg_of = 8'h4F;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'h6D;
      4'd6:    seg_of = 8'h7D;
      4'd7:    seg_of = 8'h07;
      4'd8:    seg_of = 8'h7F;
      4'd9:    seg_of = 8'h6F;
      default: seg_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    w_bcd_adj = '0;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      else                          w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
    end
  end

  assign w_bcd_ext = EXTW'(r_bcd);

  // Frame byte p drives display p counted from the right; the MSB byte is shifted out first.
  always_comb begin
    int         v_lim;
    logic       v_ovf;
    logic [3:0] v_d;
    logic [7:0] v_byte;
`ifdef LEADING_ZERO_BLANK_EN
    int         v_msd;
    v_msd = 0;
`endif
    w_frame = '0;
    v_lim   = r_neg ? NUM_DIGITS - 1 : NUM_DIGITS;
    v_ovf   = 1'b0;
    v_d     = '0;
    v_byte  = '0;
    for (int p = 0; p < EXT_DIGITS; p++) begin
      v_d = w_bcd_ext[4*p +: 4];
      if (v_d != 4'd0) begin
        if (p >= v_lim) v_ovf = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (p < NUM_DIGITS) v_msd = p;
`endif
      end
    end
    for (int p = 0; p < NUM_DIGITS; p++) begin
      v_d = w_bcd_ext[4*p +: 4];
      if (v_ovf) v_byte = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
      else if (p <= v_msd)                v_byte = seg_of(v_d);
      else if (r_neg && (p == v_msd + 1)) v_byte = SEG_DASH;
      else                                v_byte = 8'h00;
`else
      else if (r_neg && (p == NUM_DIGITS - 1)) v_byte = SEG_DASH;
      else                                     v_byte = seg_of(v_d);
`endif
      w_frame[8*p +: 8] = v_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_div      <= '0;
      r_frame    <= '0;
      r_sr_data  <= 1'b0;
      r_sr_clk   <= 1'b0;
      r_sr_latch <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_neg   <= i_2s_comp & i_data[DATA_WIDTH-1];
            r_mag   <= (i_2s_comp & i_data[DATA_WIDTH-1]) ? -i_data : i_data;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          r_bcd <= BCDW'({w_bcd_adj, r_mag[DATA_WIDTH-1]});
          r_mag <= r_mag << 1;
          if (r_cnt == CNT_LAST) r_state <= ENCODE;
          else                   r_cnt   <= r_cnt + CW'(1);
        end
        ENCODE: begin
          r_frame   <= w_frame;
          r_sr_data <= w_frame[NB-1];
          r_sr_clk  <= 1'b0;
          r_bit     <= '0;
          r_div     <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          // r_div is the phase of the current cycle within the bit: low half, then high half.
          if (r_div == DIV_LAST) begin
            r_div    <= '0;
            r_sr_clk <= 1'b0;
            if (r_bit == BIT_LAST) begin
              r_sr_data  <= 1'b0;
              r_sr_latch <= 1'b1;
              r_state    <= LATCH;
            end else begin
              r_bit     <= r_bit + BW'(1);
              r_frame   <= r_frame << 1;
              r_sr_data <= r_frame[NB-2];
            end
          end else begin
            r_div <= r_div + DW'(1);
            if (r_div == DIV_MID) r_sr_clk <= 1'b1;
          end
        end
        LATCH: begin
          if (r_div == DIV_MID) begin
            r_sr_latch <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready    = (r_state == IDLE);
  assign o_done     = (r_state == IDLE);
  assign o_sr_data  = r_sr_data;
  assign o_sr_clk   = r_sr_clk;
  assign o_sr_latch = r_sr_latch;

endmodule

// File: tb/tb_seg_shift_display_driver.sv
// tb/tb_seg_shift_display_driver.sv - scoreboard bench for seg_shift_display_driver (two configurations)
module tb_seg_shift_display_driver;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] d0, d1;
  logic        s0, s1, v0, v1;
  logic        rdy0, done0, sd0, sc0, sl0;
  logic        rdy1, done1, sd1, sc1, sl1;

  int checks = 0;
  int errors = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  logic        mc[2], md[2], ml[2];
  logic        pc[2], pd[2], pl[2];
  logic [63:0] acc[2];
  int          nbits[2], hi[2], lw[2], bad[2];

  seg_shift_display_driver u_dut0 (
    .clk(clk), .rst(rst), .i_data(d0), .i_2s_comp(s0), .i_valid(v0),
    .o_ready(rdy0), .o_done(done0), .o_sr_data(sd0), .o_sr_clk(sc0), .o_sr_latch(sl0)
  );

  seg_shift_display_driver #(.DATA_WIDTH(16), .NUM_DIGITS(3), .SR_CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_data(d1), .i_2s_comp(s1), .i_valid(v1),
    .o_ready(rdy1), .o_done(done1), .o_sr_data(sd1), .o_sr_clk(sc1), .o_sr_latch(sl1)
  );

  assign mc[0] = sc0;
  assign md[0] = sd0;
  assign ml[0] = sl0;
  assign mc[1] = sc1;
  assign md[1] = sd1;
  assign ml[1] = sl1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame_check(input int i);
    logic [63:0] e;
    int          qs;
    qs = (i == 1) ? q1.size() : q0.size();
    if (qs == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_latch: got latch pulse with frame %0h expected none", i, acc[i]);
    end else begin
      e = (i == 1) ? q1.pop_front() : q0.pop_front();
      chk($sformatf("dut%0d_frame_bytes", i), acc[i], e);
      chk($sformatf("dut%0d_frame_bits", i), nbits[i], (i == 1) ? 24 : 40);
      chk($sformatf("dut%0d_clk_high_cycles", i), hi[i], (i == 1) ? 24 : 80);
      chk($sformatf("dut%0d_latch_width", i), lw[i], (i == 1) ? 1 : 2);
      chk($sformatf("dut%0d_data_stable_clk_low", i), bad[i], 0);
    end
    acc[i]   = '0;
    nbits[i] = 0;
    hi[i]    = 0;
    lw[i]    = 0;
    bad[i]   = 0;
  endtask

  // Monitor: rebuilds each frame from the serial pins and scores it on the latch pulse.
  initial begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = '0; nbits[i] = 0; hi[i] = 0; lw[i] = 0; bad[i] = 0;
      pc[i] = 1'b0; pd[i] = 1'b0; pl[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          acc[i] = '0; nbits[i] = 0; hi[i] = 0; lw[i] = 0; bad[i] = 0;
          pc[i] = 1'b0; pd[i] = 1'b0; pl[i] = 1'b0;
        end else begin
          if (mc[i] && !pc[i]) begin
            acc[i] = {acc[i][62:0], md[i]};
            nbits[i]++;
          end
          if (mc[i]) hi[i]++;
          if (mc[i] && (md[i] !== pd[i])) bad[i]++;
          if (ml[i]) begin
            lw[i]++;
            if (mc[i]) bad[i]++;
          end
          if (!ml[i] && pl[i]) frame_check(i);
          pc[i] = mc[i];
          pd[i] = md[i];
          pl[i] = ml[i];
        end
      end
    end
  end

  task automatic issue(input int sel, input logic [15:0] d, input logic s,
                       input logic [63:0] e_nb, input logic [63:0] e_b, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!((sel == 1) ? rdy1 : rdy0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_ready_timeout: got o_ready=0 for %0d cycles expected 1", sel, n);
    end
    if (sel == 1) begin v1 = 1'b1; d1 = d; s1 = s; end
    else          begin v0 = 1'b1; d0 = d; s0 = s; end
    @(posedge clk);
    if (push) begin
      if (sel == 1) q1.push_back(BLANK ? e_b : e_nb);
      else          q0.push_back(BLANK ? e_b : e_nb);
    end
    #1;
    if (sel == 1) begin v1 = 1'b0; d1 = 16'($urandom); s1 = 1'($urandom); end
    else          begin v0 = 1'b0; d0 = 16'($urandom); s0 = 1'($urandom); end
  endtask

  task automatic wait_done(input int sel, input int lat, input string name);
    int n;
    int busy_rdy;
    n = 0;
    busy_rdy = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if ((sel == 1) ? done1 : done0) break;
      if ((sel == 1) ? rdy1 : rdy0) busy_rdy++;
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_ready_while_busy"}, busy_rdy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1ms expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    d0 = '0;   d1 = '0;
    s0 = 1'b0; s1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", rdy0, 1);
    chk("rst_done0", done0, 1);
    chk("rst_serial0", {sd0, sc0, sl0}, 0);
    chk("rst_ready1", rdy1, 1);
    chk("rst_serial1", {sd1, sc1, sl1}, 0);

    // Request concurrent with reset must not start a frame.
    v0 = 1'b1; d0 = 16'd1234;
    @(posedge clk);
    #1;
    rst = 1'b0; v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_during_rst_ignored", done0, 1);

    issue(0, 16'd1234, 1'b0, 64'h3F065B4F66, 64'h00065B4F66, 1'b1); wait_done(0, 179, "p1234");
    issue(0, 16'hFFFF, 1'b1, 64'h403F3F3F06, 64'h0000004006, 1'b1); wait_done(0, 179, "m1");
    issue(0, 16'h8000, 1'b1, 64'h4040404040, 64'h4040404040, 1'b1); wait_done(0, 179, "m32768");
    issue(0, 16'h7FFF, 1'b1, 64'h4F5B077D07, 64'h4F5B077D07, 1'b1); wait_done(0, 179, "p32767");
    issue(0, 16'hD8F1, 1'b1, 64'h406F6F6F6F, 64'h406F6F6F6F, 1'b1); wait_done(0, 179, "m9999");
    issue(0, 16'hD8F0, 1'b1, 64'h4040404040, 64'h4040404040, 1'b1); wait_done(0, 179, "m10000");
    issue(0, 16'hFFFB, 1'b1, 64'h403F3F3F6D, 64'h000000406D, 1'b1); wait_done(0, 179, "m5");
    issue(0, 16'd0,    1'b0, 64'h3F3F3F3F3F, 64'h000000003F, 1'b1); wait_done(0, 179, "zero5");

    // Request held high through a frame: second frame starts on the first IDLE cycle.
    issue(0, 16'd1234, 1'b0, 64'h3F065B4F66, 64'h00065B4F66, 1'b1);
    v0 = 1'b1; d0 = 16'd86; s0 = 1'b0;
    wait_done(0, 179, "hold_first");
    @(posedge clk);
    q0.push_back(BLANK ? 64'h0000007F7D : 64'h3F3F3F7F7D);
    #1;
    v0 = 1'b0;
    chk("hold_second_accepted", done0, 0);
    wait_done(0, 179, "hold_second");

    // Reset during bit 20 of SHIFT aborts without a latch pulse.
    issue(0, 16'd4321, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_serial_outputs", {sd0, sc0, sl0}, 0);
    chk("abort_ready", rdy0, 1);
    rst = 1'b0;
    issue(0, 16'd1234, 1'b0, 64'h3F065B4F66, 64'h00065B4F66, 1'b1); wait_done(0, 179, "after_abort");

    issue(1, 16'd0,    1'b0, 64'h3F3F3F, 64'h00003F, 1'b1); wait_done(1, 66, "n3_zero");
    issue(1, 16'd999,  1'b0, 64'h6F6F6F, 64'h6F6F6F, 1'b1); wait_done(1, 66, "n3_999");
    issue(1, 16'd1000, 1'b0, 64'h404040, 64'h404040, 1'b1); wait_done(1, 66, "n3_1000");
    issue(1, 16'hFF9D, 1'b1, 64'h406F6F, 64'h406F6F, 1'b1); wait_done(1, 66, "n3_m99");
    issue(1, 16'hFF9C, 1'b1, 64'h404040, 64'h404040, 1'b1); wait_done(1, 66, "n3_m100");
    issue(1, 16'hFFF9, 1'b1, 64'h403F07, 64'h004007, 1'b1); wait_done(1, 66, "n3_m7");
    issue(1, 16'd7,    1'b0, 64'h3F3F07, 64'h000007, 1'b1); wait_done(1, 66, "n3_7");

    repeat (5) @(posedge clk);
    #1;
    chk("dut0_frames_outstanding", q0.size(), 0);
    chk("dut1_frames_outstanding", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
